// File: rtl/snake_control.sv
// snake_control: FSM sequencer for the snake game datapath.
// Drives the per-cycle strobes for the segment RAM, head register, food and
// plot logic, latches the player direction, and stops the game on death.
// Optional feature macro: SNAKE_CTRL_PAUSE_EN adds a 'pause' input that
// freezes the frame timer and ignores key requests while the FSM is in WAIT.

module snake_control #(
    parameter int FRAME_TICKS = 833333,
    parameter int TW          = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        go,
    input  logic        key_valid,
    input  logic [2:0]  key_dir,
    input  logic        is_dead,
    input  logic [10:0] length,
`ifdef SNAKE_CTRL_PAUSE_EN
    input  logic        pause,
`endif
    output logic        waiting,
    output logic        ld_head,
    output logic        ld_q_def,
    output logic        inc_address,
    output logic        rst_address,
    output logic        draw_q,
    output logic        update_head,
    output logic        ld_head_into_prev,
    output logic        ld_q_into_curr,
    output logic        ld_prev_into_q,
    output logic        ld_curr_into_prev,
    output logic        draw_curr,
    output logic        food_en,
    output logic [1:0]  cnt_status,
    output logic [2:0]  dir,
    output logic        game_over
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        INIT   = 4'd1,
        FILL   = 4'd2,
        D_RD   = 4'd3,
        D_PLOT = 4'd4,
        F_PLOT = 4'd5,
        WAIT   = 4'd6,
        MOVE   = 4'd7,
        UPD    = 4'd8,
        S_RD   = 4'd9,
        S_CUR  = 4'd10,
        S_WR   = 4'd11,
        DEAD   = 4'd12
    } state_t;

    localparam logic [TW-1:0] TIMER_LAST = TW'(FRAME_TICKS - 1);

    state_t        state_r;
    state_t        state_next_s;
    logic [10:0]   seg_r;
    logic [1:0]    cnt_r;
    logic [TW-1:0] timer_r;
    logic          pend_r;
    logic [2:0]    pend_dir_r;
    logic [10:0]   seg_last_s;
    logic          paused_s;
    logic          key_ok_s;
    logic          req_valid_s;
    logic [2:0]    req_dir_s;

    // A request is the exact reverse when it stays on the same axis but flips sign.
    function automatic logic is_reverse(input logic [2:0] cur, input logic [2:0] req);
        logic rev;
        if (cur[2] != req[2]) begin
            rev = 1'b0;
        end else if (req[2]) begin
            rev = (cur[1] != req[1]);
        end else begin
            rev = (cur[0] != req[0]);
        end
        return rev;
    endfunction

    assign seg_last_s = length - 11'd1;

`ifdef SNAKE_CTRL_PAUSE_EN
    assign paused_s = pause & (state_r == WAIT);
`else
    assign paused_s = 1'b0;
`endif

    assign key_ok_s    = key_valid & ~paused_s;
    assign req_valid_s = key_ok_s | pend_r;
    assign req_dir_s   = key_ok_s ? key_dir : pend_dir_r;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and Moore strobe decode from state and seg/cnt/timer counters.
    always_comb begin
        state_next_s      = state_r;
        waiting           = 1'b0;
        ld_head           = 1'b0;
        ld_q_def          = 1'b0;
        inc_address       = 1'b0;
        rst_address       = 1'b0;
        draw_q            = 1'b0;
        update_head       = 1'b0;
        ld_head_into_prev = 1'b0;
        ld_q_into_curr    = 1'b0;
        ld_prev_into_q    = 1'b0;
        ld_curr_into_prev = 1'b0;
        draw_curr         = 1'b0;
        food_en           = 1'b0;
        cnt_status        = 2'd0;
        game_over         = 1'b0;
        case (state_r)
            IDLE: begin
                if (go) begin
                    state_next_s = INIT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            INIT: begin
                ld_head      = 1'b1;
                rst_address  = 1'b1;
                state_next_s = FILL;
            end
            FILL: begin
                ld_q_def = 1'b1;
                if (seg_r == seg_last_s) begin
                    rst_address  = 1'b1;
                    state_next_s = D_RD;
                end else begin
                    inc_address  = 1'b1;
                    state_next_s = FILL;
                end
            end
            D_RD: begin
                state_next_s = D_PLOT;
            end
            D_PLOT: begin
                draw_q     = 1'b1;
                cnt_status = cnt_r;
                if (cnt_r == 2'd3) begin
                    if (seg_r < seg_last_s) begin
                        inc_address  = 1'b1;
                        state_next_s = D_RD;
                    end else begin
                        rst_address  = 1'b1;
                        state_next_s = F_PLOT;
                    end
                end else begin
                    state_next_s = D_PLOT;
                end
            end
            F_PLOT: begin
                food_en    = 1'b1;
                cnt_status = cnt_r;
                if (cnt_r == 2'd3) begin
                    state_next_s = WAIT;
                end else begin
                    state_next_s = F_PLOT;
                end
            end
            WAIT: begin
                waiting = 1'b1;
                if (!paused_s && (timer_r == TIMER_LAST)) begin
                    state_next_s = MOVE;
                end else begin
                    state_next_s = WAIT;
                end
            end
            MOVE: begin
                ld_head_into_prev = 1'b1;
                rst_address       = 1'b1;
                state_next_s      = UPD;
            end
            UPD: begin
                update_head  = 1'b1;
                state_next_s = S_RD;
            end
            S_RD: begin
                state_next_s = S_CUR;
            end
            S_CUR: begin
                ld_q_into_curr = 1'b1;
                // The datapath collision compare is only meaningful here.
                if (is_dead) begin
                    state_next_s = DEAD;
                end else begin
                    state_next_s = S_WR;
                end
            end
            S_WR: begin
                ld_prev_into_q    = 1'b1;
                ld_curr_into_prev = 1'b1;
                if (seg_r < seg_last_s) begin
                    inc_address  = 1'b1;
                    state_next_s = S_RD;
                end else begin
                    rst_address  = 1'b1;
                    state_next_s = D_RD;
                end
            end
            DEAD: begin
                game_over    = 1'b1;
                state_next_s = DEAD;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Segment counter tracking the datapath RAM address.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg_r <= 11'd0;
        end else if (rst_address) begin
            seg_r <= 11'd0;
        end else if (inc_address) begin
            seg_r <= seg_r + 11'd1;
        end else begin
            seg_r <= seg_r;
        end
    end

    // Plot sub-pixel counter: runs only while plotting, wraps after 3.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= 2'd0;
        end else if ((state_r == D_PLOT) || (state_r == F_PLOT)) begin
            cnt_r <= cnt_r + 2'd1;
        end else begin
            cnt_r <= 2'd0;
        end
    end

    // Frame timer: cleared outside WAIT, holds while paused.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer_r <= '0;
        end else if (state_r != WAIT) begin
            timer_r <= '0;
        end else if (paused_s) begin
            timer_r <= timer_r;
        end else begin
            timer_r <= timer_r + TW'(1);
        end
    end

    // Direction latch; requests seen during UPD are deferred one cycle so the
    // head update uses a stable direction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dir        <= 3'b100;
            pend_r     <= 1'b0;
            pend_dir_r <= 3'b000;
        end else if (state_r == UPD) begin
            if (key_ok_s) begin
                pend_r     <= 1'b1;
                pend_dir_r <= key_dir;
            end else begin
                pend_r     <= pend_r;
                pend_dir_r <= pend_dir_r;
            end
        end else begin
            pend_r <= 1'b0;
            if (req_valid_s && !is_reverse(dir, req_dir_s)) begin
                dir <= req_dir_s;
            end else begin
                dir <= dir;
            end
        end
    end

endmodule

// File: tb/tb_snake_control.sv
// Directed testbench for snake_control with FRAME_TICKS=4.
module tb_snake_control;

    localparam int FT = 4;

    localparam logic [12:0] B_WAIT = 13'h1000;
    localparam logic [12:0] B_LDH  = 13'h0800;
    localparam logic [12:0] B_QDEF = 13'h0400;
    localparam logic [12:0] B_INC  = 13'h0200;
    localparam logic [12:0] B_RSTA = 13'h0100;
    localparam logic [12:0] B_DRQ  = 13'h0080;
    localparam logic [12:0] B_UPD  = 13'h0040;
    localparam logic [12:0] B_HP   = 13'h0020;
    localparam logic [12:0] B_QC   = 13'h0010;
    localparam logic [12:0] B_PQ   = 13'h0008;
    localparam logic [12:0] B_CP   = 13'h0004;
    localparam logic [12:0] B_FOOD = 13'h0001;
    localparam logic [12:0] B_NONE = 13'h0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        go;
    logic        key_valid;
    logic [2:0]  key_dir;
    logic        is_dead;
    logic [10:0] length;
`ifdef SNAKE_CTRL_PAUSE_EN
    logic        pause;
`endif
    logic waiting, ld_head, ld_q_def, inc_address, rst_address, draw_q;
    logic update_head, ld_head_into_prev, ld_q_into_curr, ld_prev_into_q;
    logic ld_curr_into_prev, draw_curr, food_en, game_over;
    logic [1:0]  cnt_status;
    logic [2:0]  dir;
    logic [12:0] bus;

    int n_pass  = 0;
    int n_total = 0;
    int pq_count;
    logic [2:0] exp_dir;

    always #5 clk = ~clk;

    snake_control #(.FRAME_TICKS(FT), .TW(20)) dut (
        .clk(clk), .rst(rst), .go(go), .key_valid(key_valid), .key_dir(key_dir),
        .is_dead(is_dead), .length(length),
`ifdef SNAKE_CTRL_PAUSE_EN
        .pause(pause),
`endif
        .waiting(waiting), .ld_head(ld_head), .ld_q_def(ld_q_def),
        .inc_address(inc_address), .rst_address(rst_address), .draw_q(draw_q),
        .update_head(update_head), .ld_head_into_prev(ld_head_into_prev),
        .ld_q_into_curr(ld_q_into_curr), .ld_prev_into_q(ld_prev_into_q),
        .ld_curr_into_prev(ld_curr_into_prev), .draw_curr(draw_curr),
        .food_en(food_en), .cnt_status(cnt_status), .dir(dir), .game_over(game_over)
    );

    assign bus = {waiting, ld_head, ld_q_def, inc_address, rst_address, draw_q,
                  update_head, ld_head_into_prev, ld_q_into_curr, ld_prev_into_q,
                  ld_curr_into_prev, draw_curr, food_en};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_start(input int len);
        go = 1'b1;
        step();
        go = 1'b0;
        chk("init", 32'(bus), 32'(B_LDH | B_RSTA));
        for (int i = 0; i < len; i++) begin
            step();
            chk("fill", 32'(bus), 32'(B_QDEF | ((i == len - 1) ? B_RSTA : B_INC)));
        end
    endtask

    task automatic do_draw(input int len, input int nwait);
        for (int i = 0; i < len; i++) begin
            step();
            chk("d_rd", 32'(bus), 32'(B_NONE));
            for (int j = 0; j < 4; j++) begin
                step();
                chk("d_plot", 32'(bus),
                    32'(B_DRQ | ((j == 3) ? ((i == len - 1) ? B_RSTA : B_INC) : B_NONE)));
                chk("d_cnt", 32'(cnt_status), 32'(j));
            end
        end
        for (int j = 0; j < 4; j++) begin
            step();
            chk("f_plot", 32'(bus), 32'(B_FOOD));
            chk("f_cnt", 32'(cnt_status), 32'(j));
        end
        for (int k = 0; k < nwait; k++) begin
            step();
            chk("wait", 32'(bus), 32'(B_WAIT));
        end
    endtask

    task automatic do_move_upd();
        step();
        chk("move", 32'(bus), 32'(B_HP | B_RSTA));
        step();
        chk("upd", 32'(bus), 32'(B_UPD));
    endtask

    task automatic do_shift(input int len, input int dead_at, input bit rd_done);
        pq_count = 0;
        for (int i = 0; i < len; i++) begin
            if (!(rd_done && i == 0)) begin
                step();
                chk("s_rd", 32'(bus), 32'(B_NONE));
            end
            if (i == dead_at) is_dead = 1'b1;
            step();
            chk("s_cur", 32'(bus), 32'(B_QC));
            if (i == 0) chk("s_dir", 32'(dir), 32'(exp_dir));
            if (i == dead_at) begin
                step();
                chk("dead_entry", 32'(bus), 32'(B_NONE));
                chk("dead_go", 32'(game_over), 32'd1);
                return;
            end
            step();
            chk("s_wr", 32'(bus), 32'(B_PQ | B_CP | ((i == len - 1) ? B_RSTA : B_INC)));
            pq_count += int'(ld_prev_into_q);
        end
    endtask

    initial begin
        rst = 1'b0; go = 1'b0; key_valid = 1'b0; key_dir = 3'b000;
        is_dead = 1'b0; length = 11'd6;
`ifdef SNAKE_CTRL_PAUSE_EN
        pause = 1'b0;
`endif
        step();
        chk("rst_strobes", 32'(bus), 32'(B_NONE));
        chk("rst_cnt", 32'(cnt_status), 32'd0);
        chk("rst_dir", 32'(dir), 32'h4);
        chk("rst_go", 32'(game_over), 32'd0);
        rst = 1'b1;
        step();
        step();
        chk("idle", 32'(bus), 32'(B_NONE));

        // Direction latch: reverse ignored, perpendicular taken next cycle.
        key_valid = 1'b1; key_dir = 3'b110;
        step();
        key_valid = 1'b0;
        chk("dir_rev", 32'(dir), 32'h4);
        key_valid = 1'b1; key_dir = 3'b001;
        step();
        key_valid = 1'b0;
        chk("dir_new", 32'(dir), 32'h1);
        exp_dir = 3'b001;

        // Frame 1, length 6.
        do_start(6);
        do_draw(6, FT);
        do_move_upd();
        do_shift(6, -1, 1'b0);
        chk("pq_count6", 32'(pq_count), 32'd6);

        // Frame 2: redraw, key during UPD deferred, death on 3rd S_CUR.
        do_draw(6, FT);
        do_move_upd();
        key_valid = 1'b1; key_dir = 3'b100;
        step();
        key_valid = 1'b0;
        chk("s_rd_upd", 32'(bus), 32'(B_NONE));
        chk("dir_frozen", 32'(dir), 32'h1);
        exp_dir = 3'b100;
        do_shift(6, 2, 1'b1);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("dead_hold", 32'(bus), 32'(B_NONE));
            chk("dead_go_hold", 32'(game_over), 32'd1);
        end
        is_dead = 1'b0;
        #1 rst = 1'b0;
        #1 chk("dead_rst", 32'(game_over), 32'd0);
        step();
        rst = 1'b1;
        step();
        chk("idle2", 32'(bus), 32'(B_NONE));
        chk("idle2_dir", 32'(dir), 32'h4);

        // Async reset in the middle of D_PLOT, length 1.
        key_valid = 1'b1; key_dir = 3'b000;
        step();
        key_valid = 1'b0;
        chk("dir_left", 32'(dir), 32'h0);
        length = 11'd1;
        do_start(1);
        step();
        chk("d_rd1", 32'(bus), 32'(B_NONE));
        step();
        chk("d_plot1", 32'(bus), 32'(B_DRQ));
        step();
        chk("d_cnt1", 32'(cnt_status), 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("mid_rst_strobes", 32'(bus), 32'(B_NONE));
        chk("mid_rst_cnt", 32'(cnt_status), 32'd0);
        chk("mid_rst_dir", 32'(dir), 32'h4);
        chk("mid_rst_go", 32'(game_over), 32'd0);
        step();
        rst = 1'b1;
        step();
        step();
        chk("idle3", 32'(bus), 32'(B_NONE));

        // Full frame with length 1.
        exp_dir = 3'b100;
        do_start(1);
        do_draw(1, FT);
        do_move_upd();
        do_shift(1, -1, 1'b0);
        chk("pq_count1", 32'(pq_count), 32'd1);

`ifdef SNAKE_CTRL_PAUSE_EN
        // Pause for 10 cycles in WAIT stretches it to FT+10; keys ignored.
        do_draw(1, 0);
        for (int k = 0; k < FT + 10; k++) begin
            step();
            chk("wait_pause", 32'(bus), 32'(B_WAIT));
            if (k == 0) begin
                pause = 1'b1;
                key_valid = 1'b1;
                key_dir = 3'b001;
            end
            if (k == 1) key_valid = 1'b0;
            if (k == 10) pause = 1'b0;
        end
        step();
        chk("move_after_pause", 32'(bus), 32'(B_HP | B_RSTA));
        chk("paused_key", 32'(dir), 32'h4);
`else
        do_draw(1, FT);
        step();
        chk("move_len1", 32'(bus), 32'(B_HP | B_RSTA));
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/snake_control.md
Name: snake_control

Overview:
- FSM sequencer for the snake game datapath (segment RAM, head register, food and plot logic).
- Issues every per-cycle datapath control strobe: initial body fill, per-frame redraw of body and food, frame-rate wait, head move, and body shift through RAM.
- Latches player direction and stops the game on death.
- Sits between the keyboard/button decoder and the datapath; plot outputs of the datapath go to the VGA adapter.

Parameters:
- FRAME_TICKS, 833333, clk cycles per game frame (60 Hz at 50 MHz); must be >= 2.
- TW, 20, width of the frame timer; must hold FRAME_TICKS-1.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low
- go  in  1  start request; level, sampled in IDLE
- key_valid  in  1  one-cycle strobe: new direction request present
- key_dir  in  3  requested direction, same encoding as dir
- is_dead  in  1  collision flag from datapath (registered there)
- length  in  11  current segment count from datapath, 1..2047
- waiting, ld_head, ld_q_def, inc_address, rst_address, draw_q, update_head, ld_head_into_prev, ld_q_into_curr, ld_prev_into_q, ld_curr_into_prev, draw_curr, food_en  out  1 each  datapath strobes
- cnt_status  out  2  plot sub-pixel index, {dx,dy}
- dir  out  3  registered direction: [2]=1 vertical ([1]=1 +y, 0 -y); [2]=0 horizontal ([0]=1 +x, 0 -x)
- game_over  out  1  high in DEAD

Behaviour:
- Reset: state IDLE; all strobes 0; cnt_status=0; dir=3'b100 (up); seg counter=0; frame timer=0; game_over=0.
- Strobes are Moore outputs decoded from the state and seg/cnt counters. No strobe is ever registered twice.
- Internal seg counter (11b) mirrors the datapath address. It clears whenever rst_address is asserted and increments whenever inc_address is asserted.
- Segment RAM read latency: address changes at edge k, and q is valid after edge k+1. Each segment visit therefore starts with one RD wait cycle.
- IDLE: all strobes 0. When go=1, move to INIT.
- INIT (1 cycle): ld_head=1, rst_address=1. Next state is FILL.
- FILL: ld_q_def=1 and inc_address=1 every cycle. Leave after the cycle where seg==length-1 (exactly length writes), asserting rst_address on the exit edge instead of inc_address. Next state is D_RD.
- D_RD (1 cycle) -> D_PLOT (4 cycles): draw_q=1, cnt_status=0,1,2,3.
  - On cnt_status=3, if seg<length-1: inc_address=1, go to D_RD.
  - Otherwise: rst_address=1, go to F_PLOT.
- F_PLOT (4 cycles): food_en=1, cnt_status 0..3. Next state is WAIT with the frame timer cleared.
- WAIT: waiting=1. Timer counts to FRAME_TICKS-1, then MOVE. Total WAIT length is exactly FRAME_TICKS cycles.
- MOVE (1 cycle): ld_head_into_prev=1, rst_address=1. Next state is UPD.
- UPD (1 cycle): update_head=1. Next state is S_RD.
- S_RD (1 cycle) -> S_CUR (1 cycle): ld_q_into_curr=1 -> S_WR (1 cycle): ld_prev_into_q=1, ld_curr_into_prev=1.
  - If seg<length-1: inc_address=1, go to S_RD.
  - Otherwise: rst_address=1, go to D_RD.
- Death: is_dead is sampled in S_CUR only, because the datapath compare is valid there. If is_dead=1, go to DEAD at the next edge with no RAM write that frame.
- DEAD: all strobes 0, game_over=1. Absorbing; exit only via rst.
- Direction latch: on key_valid, dir<=key_dir unless key_dir is the exact reverse of dir (same axis, opposite sign), in which case the request is ignored.
  - Requests with key_dir[2]=0 compare only bit [0]; requests with key_dir[2]=1 compare only bit [1].
  - dir is frozen during UPD. A key_valid arriving in UPD is applied the following cycle.
- length=1: FILL writes one entry, draw visits one segment, shift does one iteration.
- length changes (food eaten) only during WAIT. The next FILL/draw/shift uses the new value, and the extra tail slot is written by the last S_WR.
- rst mid-frame: immediate return to IDLE, outputs to reset values.

Optional Feature:
- SNAKE_CTRL_PAUSE_EN: adds input port pause (1b).
  - While pause=1 in WAIT, the frame timer holds and waiting stays 1.
  - key_valid is ignored while paused. Other states are unaffected, so pause takes effect at the next WAIT.
- Without the macro: no pause port; the timer always runs.

Test Plan:
- Reset then go=1, length=6, FRAME_TICKS=4:
  - INIT 1 cycle, then ld_q_def high for exactly 6 cycles.
  - Then 6x(1 RD + 4 draw_q) with cnt_status 0..3 each, then 4 food_en cycles, then waiting high exactly 4 cycles.
- After WAIT: MOVE, UPD, then 6x(S_RD, S_CUR, S_WR). Check ld_prev_into_q count=6 and rst_address asserted at end, followed by redraw.
- dir=100 with key_dir=110 (reverse) -> dir stays 100; key_dir=001 -> dir=001 next cycle; key_valid during UPD -> applied one cycle later.
- is_dead=1 during the 3rd S_CUR -> DEAD next edge; no further strobes; game_over=1 held until rst low.
- rst pulsed low during D_PLOT -> all outputs 0 and dir=100 immediately (async); IDLE until go.
- SNAKE_CTRL_PAUSE_EN defined, pause=1 for 10 cycles inside WAIT -> WAIT lasts FRAME_TICKS+10 cycles.
